// File: rtl/sap_controller.sv
`default_nettype none
// ============================================================================
// Module      : sap_controller
// Description : Control sequencer for the SAP-1 datapath. A six-state one-hot
//               ring counter (T1..T6) combined with opcode decode drives the
//               bus output enables, load strobes, PC increment and ALU
//               subtract select. T-states advance on a free-running clock
//               divider or on one debounced step-button press per state.
// Revision    : 1.0 - initial release
// ============================================================================
module sap_controller #(
    parameter int CLK_DIV = 27000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run_mode,
    input  logic       step_n,
    input  logic [3:0] opcode,
    output logic       pc_oe,
    output logic       pc_inc,
    output logic       mar_load,
    output logic       ram_oe,
    output logic       ir_load,
    output logic       ir_oe,
    output logic       a_load,
    output logic       a_oe,
    output logic       b_load,
    output logic       sum_oe,
    output logic       sub,
    output logic       out_load,
    output logic       halted,
    output logic [5:0] t_state
);

    localparam int               DIV_W      = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [3:0] C_OP_LDA = 4'b0000;
    localparam logic [3:0] C_OP_ADD = 4'b0001;
    localparam logic [3:0] C_OP_SUB = 4'b0010;
    localparam logic [3:0] C_OP_OUT = 4'b1110;
    localparam logic [3:0] C_OP_HLT = 4'b1111;

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } t_state_e;

    t_state_e         r_state;
    t_state_e         w_next_state;
    logic [DIV_W-1:0] r_div;
    logic             r_step_prev;
    logic             r_armed;
    logic             r_halted;
    logic             w_tick;
    logic             w_halt_set;

    logic w_pc_oe, w_pc_inc, w_mar_load, w_ram_oe, w_ir_load, w_ir_oe;
    logic w_a_load, w_a_oe, w_b_load, w_sum_oe, w_sub, w_out_load;

    // Run-mode divider: counts 0..CLK_DIV-1 and wraps; parked at 0 in step mode
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= '0;
        end else if (!run_mode) begin
            r_div <= '0;
        end else if (r_div == C_DIV_LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Step-button history tracks in both modes so a mode switch with the
    // button held low cannot look like a fresh falling edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_step_prev <= 1'b1;
        end else begin
            r_step_prev <= step_n;
        end
    end

    // Blocks any tick in the first cycle after reset release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
        end
    end

    assign w_tick = r_armed & (run_mode ? (r_div == C_DIV_LAST)
                                        : (r_step_prev & ~step_n));

    // Ring counter and halt flag registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= T1;
            r_halted <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_halt_set) begin
                r_halted <= 1'b1;
            end
        end
    end

    // Next-state and control-word decode; strobes qualified by the tick,
    // enables held for the whole T-state, everything silent once halted
    always_comb begin
        w_next_state = r_state;
        w_halt_set   = 1'b0;
        w_pc_oe      = 1'b0;
        w_pc_inc     = 1'b0;
        w_mar_load   = 1'b0;
        w_ram_oe     = 1'b0;
        w_ir_load    = 1'b0;
        w_ir_oe      = 1'b0;
        w_a_load     = 1'b0;
        w_a_oe       = 1'b0;
        w_b_load     = 1'b0;
        w_sum_oe     = 1'b0;
        w_sub        = 1'b0;
        w_out_load   = 1'b0;

        if (!r_halted) begin
            unique case (r_state)
                T1: begin
                    w_pc_oe    = 1'b1;
                    w_mar_load = w_tick;
                end
                T2: begin
                    w_pc_inc = w_tick;
                end
                T3: begin
                    w_ram_oe  = 1'b1;
                    w_ir_load = w_tick;
                end
                T4: begin
                    case (opcode)
                        C_OP_LDA, C_OP_ADD, C_OP_SUB: begin
                            w_ir_oe    = 1'b1;
                            w_mar_load = w_tick;
                        end
                        C_OP_OUT: begin
                            w_a_oe     = 1'b1;
                            w_out_load = w_tick;
                        end
                        C_OP_HLT: begin
                            w_halt_set = w_tick;
                        end
                        default: ;
                    endcase
                end
                T5: begin
                    case (opcode)
                        C_OP_LDA: begin
                            w_ram_oe = 1'b1;
                            w_a_load = w_tick;
                        end
                        C_OP_ADD, C_OP_SUB: begin
                            w_ram_oe = 1'b1;
                            w_b_load = w_tick;
                        end
                        default: ;
                    endcase
                end
                T6: begin
                    case (opcode)
                        C_OP_ADD: begin
                            w_sum_oe = 1'b1;
                            w_a_load = w_tick;
                        end
                        C_OP_SUB: begin
                            w_sum_oe = 1'b1;
                            w_sub    = 1'b1;
                            w_a_load = w_tick;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase

            // HLT freezes the counter at T4 instead of rotating
            if (w_tick && !w_halt_set) begin
                w_next_state = t_state_e'({r_state[4:0], r_state[5]});
            end
        end
    end

    // Reset gates the control word directly so it drops without a clock edge
    assign pc_oe    = reset_n & w_pc_oe;
    assign pc_inc   = reset_n & w_pc_inc;
    assign mar_load = reset_n & w_mar_load;
    assign ram_oe   = reset_n & w_ram_oe;
    assign ir_load  = reset_n & w_ir_load;
    assign ir_oe    = reset_n & w_ir_oe;
    assign a_load   = reset_n & w_a_load;
    assign a_oe     = reset_n & w_a_oe;
    assign b_load   = reset_n & w_b_load;
    assign sum_oe   = reset_n & w_sum_oe;
    assign sub      = reset_n & w_sub;
    assign out_load = reset_n & w_out_load;
    assign halted   = r_halted;
    assign t_state  = r_state;

endmodule
`default_nettype wire

// File: doc/sap_controller.md
Name: sap_controller

Overview:
- Control sequencer for the SAP-1 datapath; it sits directly upstream of the register file, including the A register.
- A six-state ring counter (T1..T6) plus opcode decode produces the control word: loads, output enables, PC increment, subtract select.
- Advances in free-running mode from an internal clock divider, or one T-state per debounced step-button press.
- Drives the existing register and bus blocks; no datapath logic inside.

Parameters:
- CLK_DIV, 27000000, clk cycles per T-state in run mode (minimum 2); divider width is derived from it.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- run_mode  input  1  1 = free-run on divider, 0 = manual step
- step_n  input  1  debounced step button, active-low, synchronous to clk
- opcode  input  4  instruction-register high nibble
- pc_oe  output  1  program counter drives bus
- pc_inc  output  1  program counter increment strobe
- mar_load  output  1  MAR load strobe
- ram_oe  output  1  RAM drives bus
- ir_load  output  1  IR load strobe
- ir_oe  output  1  IR low nibble drives bus
- a_load  output  1  A register load strobe
- a_oe  output  1  A register drives bus
- b_load  output  1  B register load strobe
- sum_oe  output  1  ALU drives bus
- sub  output  1  ALU subtract select
- out_load  output  1  output register load strobe
- halted  output  1  HLT executed
- t_state  output  6  one-hot ring counter, bit 0 = T1

Behaviour:
- Reset (async, reset_n low):
  - t_state = 000001 (T1); halted = 0; divider = 0; step edge detector primed to 1.
  - All control outputs are 0 while reset_n is low.
  - Reset mid-instruction aborts it; no strobe is emitted in the release cycle.
- Tick generation:
  - Run mode: divider counts 0..CLK_DIV-1; tick = 1 for one cycle when divider = CLK_DIV-1, then it wraps to 0.
  - Divider is held at 0 while run_mode = 0.
  - Step mode: tick = 1 for one cycle on a falling edge of step_n (previous 1, current 0). A held button gives exactly one tick.
  - Edges of step_n are ignored in run mode.
  - Switching mode never produces a spurious tick.
- Strobes vs. enables:
  - Strobes (pc_inc, mar_load, ir_load, a_load, b_load, out_load) are asserted only in the tick cycle of the relevant T-state: single-cycle pulses.
  - Level signals (pc_oe, ram_oe, ir_oe, a_oe, sum_oe, sub) are held for the entire T-state.
- State advance: on each tick, t_state rotates left (T6 wraps to T1) unless halted.
- Decode (opcode is read from T4 onward; IR loads at the T3 tick):
  - T1: pc_oe, mar_load
  - T2: pc_inc
  - T3: ram_oe, ir_load
  - T4:
    - LDA 0000 / ADD 0001 / SUB 0010: ir_oe, mar_load
    - OUT 1110: a_oe, out_load
    - HLT 1111: halted set at the T4 tick
  - T5:
    - LDA: ram_oe, a_load
    - ADD/SUB: ram_oe, b_load
  - T6:
    - ADD: sum_oe, a_load
    - SUB: sum_oe, sub, a_load
- Other opcodes execute as NOP: T4..T6 assert nothing, then return to T1.
- Halt:
  - Once halted = 1, t_state freezes at T4 and every control output is 0.
  - Ticks are ignored; only reset clears halted.
- Invariant: at most one of pc_oe, ram_oe, ir_oe, a_oe, sum_oe is high in any cycle.

Test Plan:
- Reset, CLK_DIV=4, run_mode=1, opcode=0000:
  - t_state advances every 4 cycles: 000001 → 000010 → ... → 100000 → 000001.
  - mar_load pulses at cycles 3 and 15; a_load pulses at cycle 19.
- ADD (0001) fetch/execute:
  - T6 holds sum_oe=1 and sub=0 for all 4 cycles; a_load is high only in the tick cycle.
  - b_load pulses once in T5.
- SUB (0010): T6 shows sub=1 and sum_oe=1; opcode 0101 yields no T4..T6 outputs.
- Step mode:
  - Three presses with step_n held low 10 cycles each give exactly 3 advances (T1 → T4).
  - Toggling run_mode mid-state gives no extra advance.
- HLT (1111):
  - halted=1 after the T4 tick; t_state stays 001000 for 50 further ticks with all controls 0.
  - reset_n low for 1 cycle restores T1 and halted=0.
- Async reset asserted mid-T5 of LDA: outputs drop to 0 without a clock edge; no a_load after release.
